// File: rtl/lfsr_stream_cipher_if.sv
// Handshake bundle for lfsr_stream_cipher: seed channel, data-in channel,
// data-out channel and the busy status flag.
interface lfsr_stream_cipher_if #(
    parameter int unsigned W  = 16,
    parameter int unsigned DW = 8
);
    logic          seed_valid;
    logic [W-1:0]  seed;
    logic          seed_ready;
    logic          bypass;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          busy;

    modport master (
        output seed_valid, seed, bypass, in_valid, in_data, out_ready,
        input  seed_ready, in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  seed_valid, seed, bypass, in_valid, in_data, out_ready,
        output seed_ready, in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/lfsr_stream_cipher.sv
// Galois-LFSR stream cipher: XORs DW-bit words with LFSR keystream (LSB first).
// Encrypt and decrypt are the same operation given the same seed.
module lfsr_stream_cipher #(
    parameter int unsigned    W            = 16,
    parameter logic [W-1:0]   TAPS         = 16'hB400,
    parameter int unsigned    DW           = 8,
    parameter int unsigned    WARMUP       = 4,
    parameter logic [W-1:0]   DEFAULT_SEED = 16'h0001
) (
    input  logic                clk,
    input  logic                rst,
    lfsr_stream_cipher_if.slave bus
);
    localparam int unsigned CW = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);

    generate
        if (W < 8 || W > 32) begin : g_bad_w
            $error("lfsr_stream_cipher: W must lie in 8..32");
        end
        if (DW == 0 || DW > W) begin : g_bad_dw
            $error("lfsr_stream_cipher: DW must lie in 1..W");
        end
        if (DEFAULT_SEED == '0) begin : g_bad_seed
            $error("lfsr_stream_cipher: DEFAULT_SEED must be nonzero");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WARMUP,
        ST_RUN
    } state_t;

    state_t         state_reg;
    logic [W-1:0]   lfsr_reg;
    logic [W-1:0]   lfsr_next;
    logic [W-1:0]   seed_hold_reg;
    logic [CW-1:0]  cnt_reg;
    logic [DW-1:0]  keystream;
    logic           out_valid_reg;
    logic [DW-1:0]  out_data_reg;
    logic           seed_ready_int;
    logic           seed_fire;
    logic           in_ready_int;
    logic           in_fire;

    // DW Galois steps unrolled; keystream bit i is the LSB seen before step i.
    always_comb begin
        lfsr_next = lfsr_reg;
        keystream = '0;
        for (int i = 0; i < int'(DW); i++) begin
            keystream[i] = lfsr_next[0];
            if (lfsr_next[0]) begin
                lfsr_next = (lfsr_next >> 1) ^ TAPS;
            end else begin
                lfsr_next = lfsr_next >> 1;
            end
        end
    end

    // A re-key in RUN waits for the output register to empty, and takes
    // priority over a data word offered in the same cycle.
    always_comb begin
        seed_ready_int = (state_reg == ST_IDLE) ||
                         ((state_reg == ST_RUN) && !out_valid_reg);
        seed_fire      = bus.seed_valid && seed_ready_int;
        in_ready_int   = (state_reg == ST_RUN) &&
                         (!out_valid_reg || bus.out_ready) && !seed_fire;
        in_fire        = bus.in_valid && in_ready_int;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            lfsr_reg      <= DEFAULT_SEED;
            seed_hold_reg <= '0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            if (out_valid_reg && bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (seed_fire) begin
                        seed_hold_reg <= bus.seed;
                        state_reg     <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    // An all-zero state would lock the LFSR; substitute 1.
                    lfsr_reg  <= (seed_hold_reg == '0) ? W'(1) : seed_hold_reg;
                    cnt_reg   <= CW'(WARMUP);
                    state_reg <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
                end

                ST_WARMUP: begin
                    lfsr_reg <= lfsr_next;
                    cnt_reg  <= cnt_reg - CW'(1);
                    if (cnt_reg <= CW'(1)) begin
                        state_reg <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (seed_fire) begin
                        seed_hold_reg <= bus.seed;
                        state_reg     <= ST_LOAD;
                    end else if (in_fire) begin
                        out_valid_reg <= 1'b1;
                        if (bus.bypass) begin
                            out_data_reg <= bus.in_data;
                        end else begin
                            out_data_reg <= bus.in_data ^ keystream;
                            lfsr_reg     <= lfsr_next;
                        end
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.seed_ready = seed_ready_int;
    assign bus.in_ready   = in_ready_int;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_data   = out_data_reg;
    assign bus.busy       = (state_reg == ST_LOAD) || (state_reg == ST_WARMUP);
endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Scoreboard bench: three cipher instances (A encrypt, B decrypt of A's
// output, Z with no warm-up) checked against a bit-serial keystream model.
module tb_lfsr_stream_cipher;
    localparam int unsigned W        = 16;
    localparam int unsigned DW       = 8;
    localparam logic [15:0] TAPS     = 16'hB400;
    localparam int unsigned WARMUP_A = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lfsr_stream_cipher_if #(.W(W), .DW(DW)) ifa ();
    lfsr_stream_cipher_if #(.W(W), .DW(DW)) ifb ();
    lfsr_stream_cipher_if #(.W(W), .DW(DW)) ifz ();

    lfsr_stream_cipher #(.W(W), .TAPS(TAPS), .DW(DW), .WARMUP(WARMUP_A),
                         .DEFAULT_SEED(16'h0001))
        u_a (.clk(clk), .rst(rst), .bus(ifa));
    lfsr_stream_cipher #(.W(W), .TAPS(TAPS), .DW(DW), .WARMUP(WARMUP_A),
                         .DEFAULT_SEED(16'h0001))
        u_b (.clk(clk), .rst(rst), .bus(ifb));
    lfsr_stream_cipher #(.W(W), .TAPS(TAPS), .DW(DW), .WARMUP(0),
                         .DEFAULT_SEED(16'h0001))
        u_z (.clk(clk), .rst(rst), .bus(ifz));

    logic chain_mode  = 1'b0;
    logic a_out_ready = 1'b1;

    // B decrypts A's output directly when chained.
    assign ifa.out_ready = chain_mode ? ifb.in_ready : a_out_ready;
    assign ifb.in_valid  = chain_mode & ifa.out_valid;
    assign ifb.in_data   = ifa.out_data;
    assign ifb.bypass    = 1'b0;
    assign ifb.out_ready = 1'b1;
    assign ifz.out_ready = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [7:0]  qz[$];
    logic [15:0] model_a;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    function automatic logic [15:0] lstep(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    function automatic logic [7:0] kbyte(input logic [15:0] s);
        logic [15:0] x;
        logic [7:0]  k;
        x = s;
        k = '0;
        for (int i = 0; i < 8; i++) begin
            k[i] = x[0];
            x    = lstep(x);
        end
        return k;
    endfunction

    function automatic logic [15:0] ladv(input logic [15:0] s);
        logic [15:0] x;
        x = s;
        for (int i = 0; i < 8; i++) x = lstep(x);
        return x;
    endfunction

    function automatic logic [15:0] seeded(input logic [15:0] s);
        logic [15:0] x;
        x = (s == 16'h0000) ? 16'h0001 : s;
        for (int i = 0; i < int'(WARMUP_A); i++) x = ladv(x);
        return x;
    endfunction

    // Monitors: pop one expectation per output handshake.
    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (!rst) begin
            if (ifa.out_valid && ifa.out_ready) begin
                if (qa.size() == 0) check("a_spurious_out", 32'(qa.size()), 1);
                else begin e = qa.pop_front(); check("a_out_data", 32'(ifa.out_data), 32'(e)); end
            end
            if (ifb.out_valid && ifb.out_ready) begin
                if (qb.size() == 0) check("b_spurious_out", 32'(qb.size()), 1);
                else begin e = qb.pop_front(); check("b_out_data", 32'(ifb.out_data), 32'(e)); end
            end
            if (ifz.out_valid && ifz.out_ready) begin
                if (qz.size() == 0) check("z_spurious_out", 32'(qz.size()), 1);
                else begin e = qz.pop_front(); check("z_out_data", 32'(ifz.out_data), 32'(e)); end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic a_seed(input logic [15:0] s);
        int t;
        ifa.seed = s; ifa.seed_valid = 1'b1; t = 0;
        @(negedge clk);
        while (!ifa.seed_ready && t < 50) begin @(negedge clk); t++; end
        check("a_seed_accept", 32'(ifa.seed_ready), 1);
        @(posedge clk); #1;
        ifa.seed_valid = 1'b0;
        model_a = seeded(s);
    endtask

    task automatic b_seed(input logic [15:0] s);
        int t;
        ifb.seed = s; ifb.seed_valid = 1'b1; t = 0;
        @(negedge clk);
        while (!ifb.seed_ready && t < 50) begin @(negedge clk); t++; end
        check("b_seed_accept", 32'(ifb.seed_ready), 1);
        @(posedge clk); #1;
        ifb.seed_valid = 1'b0;
    endtask

    // Called at a negedge with in_valid already driven; completes one accept.
    task automatic a_finish(input logic [7:0] d, input logic byp, output logic [7:0] e);
        int t;
        t = 0;
        while (!ifa.in_ready && t < 50) begin @(negedge clk); t++; end
        check("a_in_accept", 32'(ifa.in_ready), 1);
        e = '0;
        if (ifa.in_ready) begin
            if (byp) e = d;
            else begin e = d ^ kbyte(model_a); model_a = ladv(model_a); end
            qa.push_back(e);
            if (chain_mode) qb.push_back(d);
        end
        @(posedge clk); #1;
    endtask

    task automatic a_send(input logic [7:0] d, input logic byp, output logic [7:0] e);
        ifa.in_data = d; ifa.bypass = byp; ifa.in_valid = 1'b1;
        @(negedge clk);
        a_finish(d, byp, e);
    endtask

    task automatic z_send(input logic [7:0] d, input logic [7:0] e);
        int t;
        ifz.in_data = d; ifz.bypass = 1'b0; ifz.in_valid = 1'b1; t = 0;
        @(negedge clk);
        while (!ifz.in_ready && t < 50) begin @(negedge clk); t++; end
        check("z_in_accept", 32'(ifz.in_ready), 1);
        if (ifz.in_ready) qz.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((qa.size() + qb.size() + qz.size()) != 0 && t < 300) begin
            @(posedge clk); t++;
        end
        check("scoreboard_drain", 32'(qa.size() + qb.size() + qz.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] e;
        logic [7:0] e_hold;
        int c0;
        int busy_n;
        int t;

        ifa.seed_valid = 1'b0; ifa.seed = '0; ifa.bypass = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_data = '0;
        ifb.seed_valid = 1'b0; ifb.seed = '0;
        ifz.seed_valid = 1'b0; ifz.seed = '0; ifz.bypass = 1'b0;
        ifz.in_valid = 1'b0; ifz.in_data = '0;
        model_a = 16'h0001;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(ifa.out_valid), 0);
        check("rst_out_data", 32'(ifa.out_data), 0);
        check("rst_seed_ready", 32'(ifa.seed_ready), 1);
        check("rst_in_ready", 32'(ifa.in_ready), 0);
        check("rst_busy", 32'(ifa.busy), 0);
        @(posedge clk); #1;

        // Zero seed on the no-warm-up instance falls back to state 16'h0001.
        ifz.seed = 16'h0000; ifz.seed_valid = 1'b1; t = 0;
        @(negedge clk);
        while (!ifz.seed_ready && t < 50) begin @(negedge clk); t++; end
        check("z_seed_accept", 32'(ifz.seed_ready), 1);
        @(posedge clk); #1;
        ifz.seed_valid = 1'b0;
        z_send(8'h00, 8'h01);
        z_send(8'h00, 8'h68);
        ifz.in_valid = 1'b0;
        drain();

        // A encrypts, B decrypts A's output; B must return the plaintext.
        a_seed(16'hACE1);
        b_seed(16'hACE1);
        chain_mode = 1'b1;
        for (int i = 0; i < 64; i++) a_send(8'($urandom_range(0, 255)), 1'b0, e);
        ifa.in_valid = 1'b0;
        drain();
        chain_mode = 1'b0;

        // Bypass word passes through and must not advance the LFSR.
        a_send(8'hA5, 1'b1, e);
        a_send(8'h00, 1'b0, e);
        a_send(8'h5A, 1'b0, e);
        ifa.in_valid = 1'b0;
        drain();

        // Back-pressure: held word stays stable, then full-rate streaming.
        a_out_ready = 1'b0;
        a_send(8'h3C, 1'b0, e_hold);
        ifa.in_data = 8'h11; ifa.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("hold_out_valid", 32'(ifa.out_valid), 1);
            check("hold_out_data", 32'(ifa.out_data), 32'(e_hold));
            check("hold_in_ready", 32'(ifa.in_ready), 0);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        c0 = cyc;
        a_send(8'h11, 1'b0, e);
        a_send(8'h22, 1'b0, e);
        a_send(8'h33, 1'b0, e);
        a_send(8'h44, 1'b0, e);
        check("stream_cycles", 32'(cyc - c0), 4);
        ifa.in_valid = 1'b0;
        drain();

        // Re-key in RUN with a data word offered in the same cycle.
        ifa.seed = 16'h1234; ifa.seed_valid = 1'b1;
        ifa.in_data = 8'h55; ifa.bypass = 1'b0; ifa.in_valid = 1'b1;
        @(negedge clk);
        check("rekey_seed_ready", 32'(ifa.seed_ready), 1);
        check("rekey_in_stall", 32'(ifa.in_ready), 0);
        @(posedge clk); #1;
        ifa.seed_valid = 1'b0;
        model_a = seeded(16'h1234);
        busy_n = 0;
        @(negedge clk);
        while (ifa.busy && busy_n < 20) begin
            check("rekey_busy_in_ready", 32'(ifa.in_ready), 0);
            busy_n++;
            @(negedge clk);
        end
        check("rekey_busy_cycles", 32'(busy_n), 32'(1 + WARMUP_A));
        a_finish(8'h55, 1'b0, e);
        a_send(8'h66, 1'b0, e);
        ifa.in_valid = 1'b0;
        drain();

        // Reset in the middle of warm-up returns to IDLE.
        a_seed(16'hBEEF);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_warmup_busy", 32'(ifa.busy), 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(ifa.busy), 0);
        check("post_rst_seed_ready", 32'(ifa.seed_ready), 1);
        check("post_rst_in_ready", 32'(ifa.in_ready), 0);
        check("post_rst_out_valid", 32'(ifa.out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
